mem_port_arb: RTL

- Shares one unified memory port between the fetch requester (imem) and the load/store requester (dmem) of the in-order core.
- Arbitrates request handshakes, giving dmem priority with starvation protection for imem.
- Tracks outstanding transactions in an in-order source FIFO and routes each memory response back to the requester that issued it.
- Sits between the F/M stages and the single-ported memory model or bus bridge.

---
 rtl/mem_port_arb_if.sv | 47 ++++
 rtl/mem_port_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_port_arb_if.sv
// Handshake bundle for mem_port_arb: fetch requester, load/store requester and the
// shared memory port. The arbiter takes the slave view, its environment the master view.
interface mem_port_arb_if #(
  parameter int N_BITS = 32
);
  logic              imem_req_vld;
  logic              imem_req_rdy;
  logic [N_BITS-1:0] imem_req_addr;
  logic              imem_rsp_vld;
  logic [N_BITS-1:0] imem_rsp_data;

  logic              dmem_req_vld;
  logic              dmem_req_rdy;
  logic              dmem_req_mtype;
  logic [1:0]        dmem_req_len;
  logic [N_BITS-1:0] dmem_req_addr;
  logic [N_BITS-1:0] dmem_req_wdata;
  logic              dmem_rsp_vld;
  logic [N_BITS-1:0] dmem_rsp_data;

  logic              mem_req_vld;
  logic              mem_req_rdy;
  logic              mem_req_mtype;
  logic [1:0]        mem_req_len;
  logic [N_BITS-1:0] mem_req_addr;
  logic [N_BITS-1:0] mem_req_wdata;
  logic              mem_rsp_vld;
  logic [N_BITS-1:0] mem_rsp_data;

  modport slave (
    input  imem_req_vld, imem_req_addr,
    input  dmem_req_vld, dmem_req_mtype, dmem_req_len, dmem_req_addr, dmem_req_wdata,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data,
    output dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data,
    output mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata
  );

  modport master (
    output imem_req_vld, imem_req_addr,
    output dmem_req_vld, dmem_req_mtype, dmem_req_len, dmem_req_addr, dmem_req_wdata,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data,
    input  dmem_req_rdy, dmem_rsp_vld, dmem_rsp_data,
    input  mem_req_vld, mem_req_mtype, mem_req_len, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one memory port between fetch (imem) and load/store (dmem): dmem-priority
// arbitration with imem starvation guard, and in-order response routing via a source FIFO.
module mem_port_arb #(
  parameter int N_BITS          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mem_port_arb_if.slave                        bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 rsp_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_IMEM, LOCK_DMEM} lock_e;

  lock_e                      r_lock;
  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_wrPtr;
  logic [PW-1:0]              r_rdPtr;
  logic [MAX_OUTSTANDING-1:0] r_srcFifo;
  logic [SW-1:0]              r_starveCnt;
  logic                       r_rspErr;

  logic w_selDmem;
  logic w_selVld;
  logic w_full;
  logic w_empty;
  logic w_grantOk;
  logic w_hs;
  logic w_pop;
  logic w_head;

  // A stalled request keeps its source until accepted, regardless of priority.
  always_comb begin
    w_selDmem = 1'b0;
    case (r_lock)
      LOCK_IMEM: w_selDmem = 1'b0;
      LOCK_DMEM: w_selDmem = 1'b1;
      default: begin
        if (bus.imem_req_vld && bus.dmem_req_vld)
          w_selDmem = (r_starveCnt != STARVE_MAX);
        else
          w_selDmem = bus.dmem_req_vld;
      end
    endcase
  end

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_selVld  = w_selDmem ? bus.dmem_req_vld : bus.imem_req_vld;
  assign w_grantOk = !rst && !w_full;

  assign bus.mem_req_vld   = w_grantOk && w_selVld;
  assign bus.imem_req_rdy  = w_grantOk && !w_selDmem && bus.mem_req_rdy;
  assign bus.dmem_req_rdy  = w_grantOk && w_selDmem && bus.mem_req_rdy;
  assign bus.mem_req_mtype = w_selDmem && bus.dmem_req_mtype;
  assign bus.mem_req_len   = w_selDmem ? bus.dmem_req_len : 2'd0;
  assign bus.mem_req_addr  = w_selDmem ? bus.dmem_req_addr : bus.imem_req_addr;
  assign bus.mem_req_wdata = w_selDmem ? bus.dmem_req_wdata : '0;

  assign w_hs   = bus.mem_req_vld && bus.mem_req_rdy;
  assign w_pop  = bus.mem_rsp_vld && !w_empty;
  assign w_head = r_srcFifo[r_rdPtr];

  assign bus.imem_rsp_vld  = !rst && w_pop && !w_head;
  assign bus.dmem_rsp_vld  = !rst && w_pop && w_head;
  assign bus.imem_rsp_data = bus.mem_rsp_data;
  assign bus.dmem_rsp_data = bus.mem_rsp_data;

  assign outstanding = r_count;
  assign rsp_err     = r_rspErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock      <= LOCK_NONE;
      r_count     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_srcFifo   <= '0;
      r_starveCnt <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_srcFifo[r_wrPtr] <= w_selDmem;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;

      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (bus.mem_rsp_vld && w_empty)
        r_rspErr <= 1'b1;

      // Counts dmem wins only while imem is actually waiting.
      if (!bus.imem_req_vld)
        r_starveCnt <= '0;
      else if (w_hs && !w_selDmem)
        r_starveCnt <= '0;
      else if (w_hs && r_starveCnt != STARVE_MAX)
        r_starveCnt <= r_starveCnt + 1'b1;

      if (w_hs)
        r_lock <= LOCK_NONE;
      else if (bus.mem_req_vld)
        r_lock <= w_selDmem ? LOCK_DMEM : LOCK_IMEM;
    end
  end
endmodule
